// File: rtl/aes_pkg.sv
// aes_pkg: shared byte type, legal block widths and the ShiftRows row-offset table
package aes_pkg;
    typedef logic [7:0] byte_t;
    localparam int NB_128 = 4;
    localparam int NB_192 = 6;
    localparam int NB_256 = 8;
    function automatic int sr_offset(input int nb, input int row);
        return (nb == NB_256 && row >= 2) ? row + 1 : row;
    endfunction
endpackage

// File: rtl/shift_rows_pipe_if.sv
// shift_rows_pipe_if: input/output stream handshake plus flush and busy status
interface shift_rows_pipe_if #(
    parameter int NB    = 4,
    parameter int TAG_W = 4
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic              in_inv;
    logic [TAG_W-1:0]  in_tag;
    logic [32*NB-1:0]  in_data;
    logic              out_valid;
    logic              out_ready;
    logic [32*NB-1:0]  out_data;
    logic [TAG_W-1:0]  out_tag;
    logic              busy;
    modport master (
        output flush, in_valid, in_inv, in_tag, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_tag, busy
    );
    modport slave (
        input  flush, in_valid, in_inv, in_tag, in_data, out_ready,
        output in_ready, out_valid, out_data, out_tag, busy
    );
endinterface

// File: rtl/shift_rows_perm.sv
// shift_rows_perm: combinational ShiftRows / InvShiftRows byte permutation
module shift_rows_perm
    import aes_pkg::*;
#(
    parameter int NB = 4
) (
    input  logic [32*NB-1:0] in_data,
    input  logic             inv,
    output logic [32*NB-1:0] out_data
);
    localparam int W = 32 * NB;
    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < NB; c++) begin : g_col
            localparam int FS = (c + sr_offset(NB, r)) % NB;
            localparam int IS = (c - sr_offset(NB, r) + NB) % NB;
            byte_t fwd;
            byte_t bwd;
            assign fwd = in_data[W-1-8*(r*NB+FS) -: 8];
            assign bwd = in_data[W-1-8*(r*NB+IS) -: 8];
            assign out_data[W-1-8*(r*NB+c) -: 8] = inv ? bwd : fwd;
        end
    end
endmodule

// File: rtl/shift_rows_pipe.sv
// shift_rows_pipe: permutation at the input followed by an elastic register chain
module shift_rows_pipe
    import aes_pkg::*;
#(
    parameter int NB     = 4,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input logic              clk,
    input logic              rst,
    shift_rows_pipe_if.slave bus
);
    localparam int W = 32 * NB;
    if (!(NB == NB_128 || NB == NB_192 || NB == NB_256)) begin : g_bad_nb
        $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("shift_rows_pipe: STAGES must be 1..4");
    end
    if (TAG_W < 1) begin : g_bad_tag
        $error("shift_rows_pipe: TAG_W must be at least 1");
    end
    logic [W-1:0]      perm;
    logic [STAGES-1:0] v;
    logic [STAGES-1:0] vin;
    logic [STAGES-1:0] rdy;
    logic [W-1:0]      d   [STAGES];
    logic [W-1:0]      din [STAGES];
    logic [TAG_W-1:0]  t   [STAGES];
    logic [TAG_W-1:0]  tin [STAGES];
    shift_rows_perm #(.NB(NB)) u_perm (
        .in_data  (bus.in_data),
        .inv      (bus.in_inv),
        .out_data (perm)
    );
    for (genvar k = 0; k < STAGES; k++) begin : g_link
        if (k == 0) begin : g_head
            assign vin[k] = bus.in_valid;
            assign din[k] = perm;
            assign tin[k] = bus.in_tag;
        end else begin : g_body
            assign vin[k] = v[k-1];
            assign din[k] = d[k-1];
            assign tin[k] = t[k-1];
        end
        // a stage can load unless it and every stage after it is full and the sink stalls
        assign rdy[k] = bus.out_ready || ~&(v | STAGES'((1 << k) - 1));
    end
    // elastic stages: flush drops valid bits only, data is captured only for valid entries
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v <= '0;
            for (int k = 0; k < STAGES; k++) begin
                d[k] <= '0;
                t[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (bus.flush) v[k] <= 1'b0;
                else if (rdy[k]) begin
                    v[k] <= vin[k];
                    if (vin[k]) begin
                        d[k] <= din[k];
                        t[k] <= tin[k];
                    end
                end
            end
        end
    end
    assign bus.in_ready  = rdy[0] && !bus.flush;
    assign bus.out_valid = v[STAGES-1];
    assign bus.out_data  = d[STAGES-1];
    assign bus.out_tag   = t[STAGES-1];
    assign bus.busy      = |v;
endmodule

// File: tb/tb_shift_rows_pipe.sv
// tb_shift_rows_pipe: vector table plus scoreboard checks for NB=4 and NB=8 instances
module tb_shift_rows_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    shift_rows_pipe_if #(.NB(4), .TAG_W(4)) b4();
    shift_rows_pipe_if #(.NB(8), .TAG_W(4)) b8();

    shift_rows_pipe #(.NB(4), .STAGES(2), .TAG_W(4)) d4 (.clk(clk), .rst(rst), .bus(b4));
    shift_rows_pipe #(.NB(8), .STAGES(2), .TAG_W(4)) d8 (.clk(clk), .rst(rst), .bus(b8));

    typedef struct {
        logic [255:0] d;
        logic [3:0]   t;
    } exp_t;

    typedef struct {
        bit           nb8;
        bit           inv;
        logic [255:0] din;
        logic [255:0] dexp;
    } vec_t;

    exp_t q4[$];
    exp_t q8[$];
    vec_t vec[6];
    int pass_n = 0;
    int tot_n = 0;
    int n4 = 0;
    int n8 = 0;
    bit acc4, acc8;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        tot_n++;
        if (act === req) pass_n++;
        else $display("FAIL %s actual=%h required=%h", name, act, req);
    endtask

    function automatic logic [255:0] mdl(input logic [255:0] x, input int nb, input bit inv);
        int o4[4] = '{0, 1, 2, 3};
        int o8[4] = '{0, 1, 3, 4};
        logic [255:0] y = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < nb; c++) begin
                int o = (nb == 8) ? o8[r] : o4[r];
                int s = inv ? (c - o + nb) % nb : (c + o) % nb;
                y[32*nb-1-8*(r*nb+c) -: 8] = x[32*nb-1-8*(r*nb+s) -: 8];
            end
        end
        return y;
    endfunction

    // samples both handshakes mid-cycle, updates the scoreboards, then advances one clock
    task automatic step();
        exp_t e;
        #1;
        acc4 = b4.in_valid && b4.in_ready;
        acc8 = b8.in_valid && b8.in_ready;
        if (rst) begin
            q4.delete();
            q8.delete();
        end else begin
            if (acc4) begin
                e.d = mdl({128'b0, b4.in_data}, 4, b4.in_inv);
                e.t = b4.in_tag;
                q4.push_back(e);
            end
            if (acc8) begin
                e.d = mdl(b8.in_data, 8, b8.in_inv);
                e.t = b8.in_tag;
                q8.push_back(e);
            end
            if (b4.out_valid && b4.out_ready) begin
                if (q4.size() == 0) begin
                    tot_n++;
                    $display("FAIL out4_spurious actual tag=%0d required no output", b4.out_tag);
                end else begin
                    e = q4.pop_front();
                    chk("out4_data", {128'b0, b4.out_data}, e.d);
                    chk("out4_tag", b4.out_tag, e.t);
                    n4++;
                end
            end
            if (b8.out_valid && b8.out_ready) begin
                if (q8.size() == 0) begin
                    tot_n++;
                    $display("FAIL out8_spurious actual tag=%0d required no output", b8.out_tag);
                end else begin
                    e = q8.pop_front();
                    chk("out8_data", b8.out_data, e.d);
                    chk("out8_tag", b8.out_tag, e.t);
                    n8++;
                end
            end
            if (b4.flush) q4.delete();
            if (b8.flush) q8.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        logic [127:0] dat[6];
        logic [127:0] held;
        int nxt, base, lat;
        vec[0] = '{1'b0, 1'b0, 256'h000102030405060708090a0b0c0d0e0f, 256'h00010203050607040a0b08090f0c0d0e};
        vec[1] = '{1'b0, 1'b1, 256'h000102030405060708090a0b0c0d0e0f, 256'h00010203070405060a0b08090d0e0f0c};
        vec[2] = '{1'b0, 1'b1, 256'h00010203050607040a0b08090f0c0d0e, 256'h000102030405060708090a0b0c0d0e0f};
        vec[3] = '{1'b1, 1'b0,
                   256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                   256'h0001020304050607090a0b0c0d0e0f0813141516171011121c1d1e1f18191a1b};
        vec[4] = '{1'b1, 1'b1,
                   256'h0001020304050607090a0b0c0d0e0f0813141516171011121c1d1e1f18191a1b,
                   256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f};
        vec[5] = '{1'b1, 1'b1,
                   256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                   256'h00010203040506070f08090a0b0c0d0e15161710111213141c1d1e1f18191a1b};
        for (int i = 0; i < 6; i++) dat[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
        b4.flush = 0; b4.in_valid = 0; b4.in_inv = 0; b4.in_tag = 0; b4.in_data = '0; b4.out_ready = 1;
        b8.flush = 0; b8.in_valid = 0; b8.in_inv = 0; b8.in_tag = 0; b8.in_data = '0; b8.out_ready = 1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", b4.out_valid, 0);
        chk("rst_out_data", b4.out_data, 0);
        chk("rst_out_tag", b4.out_tag, 0);
        chk("rst_busy", b4.busy, 0);
        chk("rst_busy8", b8.busy, 0);
        rst = 0;
        #1 chk("rst_in_ready", b4.in_ready, 1);
        @(negedge clk);

        // table vectors: exact two-cycle latency and fixed expected permutation
        for (int i = 0; i < 6; i++) begin
            if (vec[i].nb8) begin
                b8.in_valid = 1; b8.in_inv = vec[i].inv; b8.in_tag = 4'(i); b8.in_data = vec[i].din;
            end else begin
                b4.in_valid = 1; b4.in_inv = vec[i].inv; b4.in_tag = 4'(i); b4.in_data = vec[i].din[127:0];
            end
            step();
            b4.in_valid = 0;
            b8.in_valid = 0;
            chk("vec_early_valid", vec[i].nb8 ? b8.out_valid : b4.out_valid, 0);
            step();
            chk("vec_valid", vec[i].nb8 ? b8.out_valid : b4.out_valid, 1);
            chk("vec_data", vec[i].nb8 ? b8.out_data : {128'b0, b4.out_data}, vec[i].dexp);
            step();
        end

        // backpressure: six tagged states, sink stalled for five cycles
        base = n4;
        nxt = 0;
        b4.out_ready = 0;
        for (int i = 0; i < 5; i++) begin
            b4.in_valid = 1; b4.in_tag = 4'(nxt); b4.in_inv = nxt[0]; b4.in_data = dat[nxt];
            step();
            if (acc4) nxt++;
            if (i == 2) held = b4.out_data;
        end
        chk("bp_accepts", nxt, 2);
        chk("bp_in_ready", b4.in_ready, 0);
        chk("bp_out_valid", b4.out_valid, 1);
        chk("bp_hold_data", b4.out_data, held);
        chk("bp_hold_tag", b4.out_tag, 0);
        b4.out_ready = 1;
        for (int i = 0; i < 40 && n4 - base < 6; i++) begin
            b4.in_valid = (nxt < 6);
            if (nxt < 6) begin
                b4.in_tag = 4'(nxt); b4.in_inv = nxt[0]; b4.in_data = dat[nxt];
            end
            step();
            if (acc4) nxt++;
        end
        b4.in_valid = 0;
        chk("bp_count", n4 - base, 6);

        // flush with two entries in flight; the flush-cycle input must be refused
        b4.out_ready = 0;
        for (int i = 1; i <= 2; i++) begin
            b4.in_valid = 1; b4.in_tag = 4'(i); b4.in_inv = 0; b4.in_data = dat[i];
            step();
        end
        b4.in_tag = 4'd9; b4.flush = 1;
        #1;
        chk("flush_in_ready", b4.in_ready, 0);
        chk("flush_busy_pre", b4.busy, 1);
        step();
        b4.flush = 0; b4.in_valid = 0;
        chk("flush_busy", b4.busy, 0);
        chk("flush_out_valid", b4.out_valid, 0);
        b4.out_ready = 1;
        base = n4;
        b4.in_valid = 1; b4.in_tag = 4'd7; b4.in_inv = 1; b4.in_data = dat[3];
        step();
        b4.in_valid = 0;
        lat = 1;
        while (!b4.out_valid && lat < 10) begin
            step();
            lat++;
        end
        chk("flush_latency", lat, 2);
        chk("flush_tag7", b4.out_tag, 7);
        repeat (4) step();
        chk("flush_single", n4 - base, 1);

        // asynchronous reset mid-stream on the NB=8 instance
        for (int i = 3; i <= 4; i++) begin
            b8.in_valid = 1; b8.in_tag = 4'(i); b8.in_inv = 0; b8.in_data = {dat[i], dat[5]};
            step();
        end
        chk("pre_rst_busy", b8.busy, 1);
        b8.in_valid = 0;
        rst = 1;
        #1;
        chk("mid_rst_valid", b8.out_valid, 0);
        chk("mid_rst_data", b8.out_data, 0);
        chk("mid_rst_busy", b8.busy, 0);
        step();
        rst = 0;
        #1 chk("post_rst_in_ready", b8.in_ready, 1);
        base = n8;
        repeat (5) step();
        chk("post_rst_quiet", b8.out_valid, 0);
        chk("post_rst_no_out", n8 - base, 0);

        chk("q4_drained", q4.size(), 0);
        chk("q8_drained", q8.size(), 0);
        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end
endmodule

// File: doc/shift_rows_pipe.md
Name: shift_rows_pipe

Overview:
- Parametrised, pipelined Rijndael ShiftRows / InvShiftRows unit.
- Direction is selected per transaction, so one instance serves both the encrypt and decrypt datapaths.
- Supports block widths of NB = 4, 6 or 8 columns (128/192/256-bit state) and has a configurable register depth.
- Sits between SubBytes/InvSubBytes and MixColumns/AddRoundKey stages, with valid/ready handshakes on both sides.

Parameters:
- NB, 4, state columns; legal values 4, 6, 8; state width W = 32*NB.
- STAGES, 2, register stages, legal 1..4; also the latency in cycles.
- TAG_W, 4, width of the sideband tag carried alongside each state (min 1).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  synchronous drop of all in-flight entries
- in_valid  in  1  input state valid
- in_ready  out  1  unit can accept this cycle
- in_inv  in  1  0 = ShiftRows, 1 = InvShiftRows
- in_tag  in  TAG_W  sideband; returned unchanged with the result
- in_data  in  W  state, row-major; byte index r*NB+c; byte 0 in bits [W-1:W-8]
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- out_data  out  W  permuted state, same byte layout
- out_tag  out  TAG_W  tag of the result
- busy  out  1  any stage holds a valid entry

Behaviour:
- Reset: one clock, `clk`; reset is asynchronous and active-high on `rst`.
  - Asserting rst clears all stage valid bits, data and tags to 0.
  - out_valid=0, out_data=0, out_tag=0, busy=0.
  - in_ready=1 as soon as rst deasserts.
  - Reset mid-operation discards all in-flight states; no partial output appears.
- Row offsets Cr:
  - NB=4 or 6: C0..C3 = 0,1,2,3.
  - NB=8: C0..C3 = 0,1,3,4.
- Permutation, applied combinationally at the pipeline input, then registered:
  - Forward: out[r][c] = in[r][(c+Cr) mod NB].
  - Inverse: out[r][c] = in[r][(c-Cr+NB) mod NB].
  - Byte values are never modified.
- Pipeline and handshake:
  - STAGES elastic registers, each holding {valid, data, tag}.
  - Stage k loads when ready_k = !valid_k || ready_(k+1), where ready_STAGES = out_ready.
  - in_ready = ready_0.
  - Transfer occurs when valid && ready are both high on a rising edge.
  - Latency from input accept to out_valid is exactly STAGES cycles when there is no backpressure.
  - Throughput is 1 state per cycle.
- Ordering and hold rules:
  - Strictly in-order; tag and inv choice travel with their state.
  - Mixing inv and forward transactions back to back is legal.
  - While out_valid=1 and out_ready=0, out_data and out_tag hold stable; no entry is dropped or duplicated.
  - in_valid may drop without a handshake; there is no combinational path from in_data to out_*.
- flush:
  - Clears all valid bits at the next edge; data registers keep their values.
  - An input presented in the flush cycle is not accepted: in_ready is forced to 0 while flush=1.
  - flush has lower priority than rst.
- busy = OR of all stage valid bits.
- Illegal NB or STAGES values are rejected with an elaboration-time assertion.

Decomposition:
- aes_pkg holds:
  - typedef byte_t (8-bit)
  - function sr_offset(nb, row), returning the Cr table above
  - localparams for the legal NB values
- Sub-module shift_rows_perm (combinational; parameter NB; ports in_data, inv, out_data) implements the permutation.
- shift_rows_pipe instantiates shift_rows_perm once, followed by the elastic register chain.

Test Plan:
- NB=4, STAGES=2, inv=0, in_data=0x000102030405060708090a0b0c0d0e0f, out_ready=1 -> after 2 cycles out_data=0x00010203050607040a0b08090f0c0d0e.
- Same input with inv=1 -> out_data=0x00010203070405060a0b08090d0e0f0c.
  - Also feed the forward result back with inv=1 and confirm it returns the original input.
- NB=8, inv=0, bytes 0x00..0x1f -> row2 = 13 14 15 16 17 10 11 12 and row3 = 1c 1d 1e 1f 18 19 1a 1b.
  - Inverse restores the input.
- Backpressure: stream 6 states with tags 0..5 and hold out_ready=0 for 5 cycles.
  - in_ready falls after STAGES accepts.
  - Outputs then appear in tag order 0..5 with no loss; out_data stays stable while stalled.
- Flush with 2 entries in flight -> next cycle busy=0 and out_valid=0.
  - A following input with tag 7 emerges alone after STAGES cycles.
- Assert rst for 1 cycle mid-stream -> out_valid, out_data and busy go to 0 immediately.
  - No stale output appears afterwards, and in_ready=1 once rst deasserts.
